lsu_sequencer: RTL and testbench
================================

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1, the reset; asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, a request strobe, sampled only in IDLE.
REQ-004 SHALL have port is_load, input, 1: 1 = load, 0 = store.
REQ-005 SHALL have port load_op, input, LOAD_OP_WIDTH, a decoded load operation (LB/LH/LW/LBU/LHU).
REQ-006 SHALL have port store_op, input, STORE_OP_WIDTH, a decoded store operation (SB/SH/SW).
REQ-007 SHALL have port addr, input, 32, the byte address.
REQ-008 SHALL have port wdata, input, 32, the store data, with the operand in the low bits.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32, the extended load result, valid while done is high.
REQ-012 SHALL have port misaligned, output, 1, an alignment fault flag, valid while done is high.
REQ-013 SHALL have port illegal_op, output, 1, an unknown-operation flag, valid while done is high.
REQ-014 SHALL have port mem_valid, output, 1, the memory request valid.
REQ-015 SHALL have port mem_ready, input, 1, the memory accept/response ready.
REQ-016 SHALL have port mem_addr, output, 32, the word-aligned address (addr[31:2], 2'b00).
REQ-017 SHALL have port mem_wdata, output, 32, the lane-replicated store data.
REQ-018 SHALL have port mem_wstrb, output, 4, the byte enables; 0 on loads.
REQ-019 SHALL have port mem_rdata, input, 32, the read data, qualified by mem_ready.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-021 SHALL, in IDLE with start=1, latch is_load, load_op, store_op, addr, wdata and classify the request in that same cycle.
REQ-022 SHALL treat as misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; byte operations are never misaligned.
REQ-023 SHALL treat any load_op encoding outside the five defined loads, or store_op outside SB/SH/SW, as illegal; illegal takes priority over misaligned.
REQ-024 SHALL, for a faulting request, go IDLE->DONE without asserting mem_valid, and SHALL raise the corresponding flag with done.
REQ-025 SHALL, for a good request, go IDLE->ACCESS; mem_valid is high from the cycle after start and held, with mem_addr/mem_wdata/mem_wstrb stable, until sampled with mem_ready=1.
REQ-026 SHALL ignore mem_ready whenever mem_valid=0.
REQ-027 SHALL go ACCESS->DONE on the cycle mem_ready=1 and register the extracted load data in that cycle.
REQ-028 SHALL drive done=1 for exactly one cycle in DONE, then return to IDLE; minimum latency from start to done is 2 cycles (zero-wait memory), and 1 cycle for faults.
REQ-029 SHALL ignore start while busy=1; start in the IDLE cycle following DONE is accepted.
REQ-030 SHALL set mem_wstrb to: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-031 SHALL set mem_wdata to: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-032 SHALL extract loads as follows: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-033 SHALL drive rdata=0 for stores and faults; misaligned and illegal_op are 0 whenever done=0.

Reset
REQ-034 SHALL, on resetn low, immediately (asynchronously) force state IDLE and busy=0, done=0, mem_valid=0, mem_wstrb=0, misaligned=0, illegal_op=0, rdata=0, mem_addr=0, mem_wdata=0.
REQ-035 SHALL abandon any in-flight access on reset mid-ACCESS, with mem_valid dropping without waiting for mem_ready and no done pulse.
REQ-036 SHALL resume operation on the first clk edge after resetn deasserts, in IDLE.

Structure
REQ-037 SHALL take LOAD_OP_*, LOAD_OP_WIDTH, STORE_OP_*, STORE_OP_WIDTH from the shared riscv_defines.vh, with no local redefinition.
REQ-038 SHALL place load extraction/extension in one combinational sub-module, load_aligner (inputs load_op, addr[1:0], mem_rdata; output 32-bit result).

Verification
REQ-039 SHALL cover LB at addr 0x1003 with mem_rdata 0x80FF_FF00 and zero wait -> mem_addr 0x1000, wstrb 0, done 2 cycles after start, rdata 0xFFFF_FF80.
REQ-040 SHALL cover LHU at addr 0x2002 with mem_rdata 0xBEEF_1234 and 3 wait cycles -> mem_valid held 4 cycles with stable address, rdata 0x0000_BEEF.
REQ-041 SHALL cover SB at addr 0x3001 with wdata 0x1234_56A5 -> mem_wstrb 4'b0010, mem_wdata 0xA5A5_A5A5, done with rdata 0.
REQ-042 SHALL cover SW at addr 0x4002 -> no mem_valid, done 1 cycle after start with misaligned=1; and load_op with an undefined encoding -> illegal_op=1.
REQ-043 SHALL cover resetn pulled low mid-ACCESS -> mem_valid and busy low immediately, no done; a new LW after reset completes normally.
REQ-044 SHALL cover start held high through a transaction -> exactly one access per IDLE visit; a second request in the cycle after done is accepted.

Source files
------------

// File: rtl/lsu_sequencer_pkg.sv
// State type and request classification / store-lane helpers for the LSU sequencer.
`include "riscv_defines.vh"

package lsu_sequencer_pkg;

   typedef enum logic [1:0] {StIdle, StAccess, StDone} lsu_state_e;

   function automatic logic op_illegal(input logic                        is_load,
                                       input logic [`LOAD_OP_WIDTH-1:0]  load_op,
                                       input logic [`STORE_OP_WIDTH-1:0] store_op);
      logic bad;
      bad = 1'b1;
      if (is_load) begin
         case (load_op)
            `LOAD_OP_LB, `LOAD_OP_LH, `LOAD_OP_LW, `LOAD_OP_LBU, `LOAD_OP_LHU: bad = 1'b0;
            default: bad = 1'b1;
         endcase
      end else begin
         case (store_op)
            `STORE_OP_SB, `STORE_OP_SH, `STORE_OP_SW: bad = 1'b0;
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

   function automatic logic op_misaligned(input logic                        is_load,
                                          input logic [`LOAD_OP_WIDTH-1:0]  load_op,
                                          input logic [`STORE_OP_WIDTH-1:0] store_op,
                                          input logic [1:0]                 addr_lo);
      logic mis;
      mis = 1'b0;
      if (is_load) begin
         case (load_op)
            `LOAD_OP_LH, `LOAD_OP_LHU: mis = addr_lo[0];
            `LOAD_OP_LW:               mis = |addr_lo;
            default:                   mis = 1'b0;
         endcase
      end else begin
         case (store_op)
            `STORE_OP_SH: mis = addr_lo[0];
            `STORE_OP_SW: mis = |addr_lo;
            default:      mis = 1'b0;
         endcase
      end
      return mis;
   endfunction

   function automatic logic [3:0] store_strobe(input logic [`STORE_OP_WIDTH-1:0] store_op,
                                               input logic [1:0]                 addr_lo);
      logic [3:0] strb;
      case (store_op)
         `STORE_OP_SB: strb = 4'b0001 << addr_lo;
         `STORE_OP_SH: strb = 4'b0011 << addr_lo;
         `STORE_OP_SW: strb = 4'b1111;
         default:      strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Replicate the operand onto every lane so the strobe alone selects the target bytes.
   function automatic logic [31:0] store_lanes(input logic [`STORE_OP_WIDTH-1:0] store_op,
                                               input logic [31:0]                wdata);
      logic [31:0] lanes;
      case (store_op)
         `STORE_OP_SB: lanes = {4{wdata[7:0]}};
         `STORE_OP_SH: lanes = {2{wdata[15:0]}};
         default:      lanes = wdata;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed byte/half/word out of the read word and sign- or zero-extends it.
`include "riscv_defines.vh"

module load_aligner (
   input  logic [`LOAD_OP_WIDTH-1:0] load_op,
   input  logic [1:0]                addr,
   input  logic [31:0]               mem_rdata,
   output logic [31:0]               result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (addr)
         2'd0:    byte_lane = mem_rdata[7:0];
         2'd1:    byte_lane = mem_rdata[15:8];
         2'd2:    byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      case (load_op)
         `LOAD_OP_LB:  result = {{24{byte_lane[7]}}, byte_lane};
         `LOAD_OP_LH:  result = {{16{half_lane[15]}}, half_lane};
         `LOAD_OP_LW:  result = mem_rdata;
         `LOAD_OP_LBU: result = {24'h0, byte_lane};
         `LOAD_OP_LHU: result = {16'h0, half_lane};
         default:      result = 32'h0;
      endcase
   end

endmodule

// File: rtl/riscv_defines.vh
// Shared RISC-V load/store operation encodings (funct3-style) used by the LSU and its bench.
`ifndef RISCV_DEFINES_VH
`define RISCV_DEFINES_VH

`define LOAD_OP_WIDTH  3
`define LOAD_OP_LB     3'b000
`define LOAD_OP_LH     3'b001
`define LOAD_OP_LW     3'b010
`define LOAD_OP_LBU    3'b100
`define LOAD_OP_LHU    3'b101

`define STORE_OP_WIDTH 2
`define STORE_OP_SB    2'b00
`define STORE_OP_SH    2'b01
`define STORE_OP_SW    2'b10

`endif

// File: rtl/lsu_sequencer.sv
// Single-outstanding load/store sequencer: classify, issue one memory access, pulse done.
`include "riscv_defines.vh"

module lsu_sequencer
   import lsu_sequencer_pkg::*;
(
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic                        is_load,
   input  logic [`LOAD_OP_WIDTH-1:0]  load_op,
   input  logic [`STORE_OP_WIDTH-1:0] store_op,
   input  logic [31:0]                 addr,
   input  logic [31:0]                 wdata,
   output logic                        busy,
   output logic                        done,
   output logic [31:0]                 rdata,
   output logic                        misaligned,
   output logic                        illegal_op,
   output logic                        mem_valid,
   input  logic                        mem_ready,
   output logic [31:0]                 mem_addr,
   output logic [31:0]                 mem_wdata,
   output logic [3:0]                  mem_wstrb,
   input  logic [31:0]                 mem_rdata
);

   lsu_state_e                  state_q, state_d;
   logic                        is_load_q, is_load_d;
   logic [`LOAD_OP_WIDTH-1:0]  load_op_q, load_op_d;
   logic [`STORE_OP_WIDTH-1:0] store_op_q, store_op_d;
   logic [31:0]                 addr_q, addr_d;
   logic [31:0]                 wdata_q, wdata_d;
   logic [31:0]                 rdata_q, rdata_d;
   logic                        mis_q, mis_d;
   logic                        ill_q, ill_d;

   logic        req_illegal;
   logic        req_misaligned;
   logic [31:0] load_result;

   assign req_illegal    = op_illegal(is_load, load_op, store_op);
   assign req_misaligned = op_misaligned(is_load, load_op, store_op, addr[1:0]);

   load_aligner u_load_aligner (
      .load_op   (load_op_q),
      .addr      (addr_q[1:0]),
      .mem_rdata (mem_rdata),
      .result    (load_result)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         is_load_q  <= 1'b0;
         load_op_q  <= '0;
         store_op_q <= '0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         mis_q      <= 1'b0;
         ill_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_load_q  <= is_load_d;
         load_op_q  <= load_op_d;
         store_op_q <= store_op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         mis_q      <= mis_d;
         ill_q      <= ill_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      is_load_d  = is_load_q;
      load_op_d  = load_op_q;
      store_op_d = store_op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      mis_d      = mis_q;
      ill_d      = ill_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               is_load_d  = is_load;
               load_op_d  = load_op;
               store_op_d = store_op;
               addr_d     = addr;
               wdata_d    = wdata;
               rdata_d    = 32'h0;
               ill_d      = req_illegal;
               mis_d      = req_misaligned & ~req_illegal;
               // Faulting requests never reach the memory port.
               state_d    = (req_illegal | req_misaligned) ? StDone : StAccess;
            end
         end
         StAccess: begin
            if (mem_ready) begin
               rdata_d = is_load_q ? load_result : 32'h0;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign mem_valid  = (state_q == StAccess);
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_wdata  = store_lanes(store_op_q, wdata_q);
   assign mem_wstrb  = (mem_valid && !is_load_q) ? store_strobe(store_op_q, addr_q[1:0]) : 4'b0;
   assign rdata      = rdata_q;
   assign misaligned = done & mis_q;
   assign illegal_op = done & ill_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: transaction-level model plus per-cycle output checks.
`include "riscv_defines.vh"

module tb_lsu_sequencer;

   logic                        clk = 1'b0;
   logic                        resetn;
   logic                        start;
   logic                        is_load;
   logic [`LOAD_OP_WIDTH-1:0]  load_op;
   logic [`STORE_OP_WIDTH-1:0] store_op;
   logic [31:0]                 addr;
   logic [31:0]                 wdata;
   logic                        busy;
   logic                        done;
   logic [31:0]                 rdata;
   logic                        misaligned;
   logic                        illegal_op;
   logic                        mem_valid;
   logic                        mem_ready;
   logic [31:0]                 mem_addr;
   logic [31:0]                 mem_wdata;
   logic [3:0]                  mem_wstrb;
   logic [31:0]                 mem_rdata;

   lsu_sequencer dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .is_load    (is_load),
      .load_op    (load_op),
      .store_op   (store_op),
      .addr       (addr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .rdata      (rdata),
      .misaligned (misaligned),
      .illegal_op (illegal_op),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_ld;
      logic        fault;
      logic        mis;
      logic        ill;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  strb;
   } exp_t;

   exp_t        cur;
   int          checks = 0;
   int          passes = 0;
   int          last_lat, last_vc;
   logic [31:0] last_rdata, last_addr, last_wdata;
   logic [3:0]  last_strb;
   logic        last_mis, last_ill;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Access size in bytes; 0 marks an encoding outside the defined operations.
   function automatic int access_bytes(input logic ld, input logic [`LOAD_OP_WIDTH-1:0] lop,
                                       input logic [`STORE_OP_WIDTH-1:0] sop);
      if (ld) begin
         case (lop)
            `LOAD_OP_LB, `LOAD_OP_LBU: return 1;
            `LOAD_OP_LH, `LOAD_OP_LHU: return 2;
            `LOAD_OP_LW:               return 4;
            default:                   return 0;
         endcase
      end
      case (sop)
         `STORE_OP_SB: return 1;
         `STORE_OP_SH: return 2;
         `STORE_OP_SW: return 4;
         default:      return 0;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [`LOAD_OP_WIDTH-1:0] op,
                                            input logic [31:0] a, input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * (a % 4))) & 32'hFF;
      h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      case (op)
         `LOAD_OP_LB:  return (b >= 32'd128) ? b - 32'd256 : b;
         `LOAD_OP_LH:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         `LOAD_OP_LW:  return w;
         `LOAD_OP_LBU: return b;
         `LOAD_OP_LHU: return h;
         default:      return 32'h0;
      endcase
   endfunction

   function automatic exp_t model(input logic ld, input logic [`LOAD_OP_WIDTH-1:0] lop,
                                  input logic [`STORE_OP_WIDTH-1:0] sop, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] mrd);
      exp_t        e;
      int          n;
      int unsigned strb_i;
      n       = access_bytes(ld, lop, sop);
      e.is_ld = ld;
      e.ill   = (n == 0);
      e.mis   = 1'b0;
      if (n != 0) e.mis = ((a % n) != 0);
      e.fault = e.ill || e.mis;
      e.addr  = a & 32'hFFFF_FFFC;
      strb_i  = ((32'd1 << n) - 32'd1) << (a % 4);
      e.strb  = (ld || e.fault) ? 4'h0 : strb_i[3:0];
      if (n == 1)      e.wdata = wd[7:0] * 32'h0101_0101;
      else if (n == 2) e.wdata = wd[15:0] * 32'h0001_0001;
      else             e.wdata = wd;
      e.rdata = (ld && !e.fault) ? exp_load(lop, a, mrd) : 32'h0;
      return e;
   endfunction

   // Per-cycle compare against the current request's model.
   always @(negedge clk) begin
      if (resetn) begin
         chk("busy", 32'(busy), 32'(mem_valid | done));
         if (mem_valid) begin
            chk("valid_on_fault", 32'(cur.fault), 32'd0);
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.strb));
            if (!cur.is_ld) chk("mem_wdata", mem_wdata, cur.wdata);
         end
         if (done) begin
            chk("rdata", rdata, cur.rdata);
            chk("misaligned", 32'(misaligned), 32'(cur.mis));
            chk("illegal_op", 32'(illegal_op), 32'(cur.ill));
         end else begin
            chk("flags_quiet", 32'({misaligned, illegal_op}), 32'd0);
         end
      end
   end

   // Called just after a negedge while the DUT is idle; returns at the negedge of the idle
   // cycle following done.
   task automatic do_req(input logic ld, input logic [`LOAD_OP_WIDTH-1:0] lop,
                         input logic [`STORE_OP_WIDTH-1:0] sop, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mrd, input int waits,
                         input logic hold);
      bit seen;
      cur       = model(ld, lop, sop, a, wd, mrd);
      is_load   = ld;
      load_op   = lop;
      store_op  = sop;
      addr      = a;
      wdata     = wd;
      start     = 1'b1;
      mem_rdata = mrd;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) begin
         start    = 1'b0;
         addr     = ~a;
         wdata    = ~wd;
         load_op  = ~lop;
         store_op = ~sop;
      end
      seen       = 1'b0;
      last_lat   = 0;
      last_vc    = 0;
      last_strb  = 4'h0;
      last_addr  = 32'h0;
      last_wdata = 32'h0;
      mem_ready  = (waits == 0);
      for (int c = 1; c <= waits + 8 && !seen; c++) begin
         @(negedge clk);
         if (done) begin
            seen       = 1'b1;
            last_lat   = c;
            last_rdata = rdata;
            last_mis   = misaligned;
            last_ill   = illegal_op;
         end else begin
            if (mem_valid) begin
               last_vc++;
               last_addr  = mem_addr;
               last_strb  = mem_wstrb;
               last_wdata = mem_wdata;
            end
            @(posedge clk);
            #1;
            mem_ready = (last_vc >= waits);
         end
      end
      mem_ready = 1'b0;
      chk("latency", 32'(last_lat), cur.fault ? 32'd1 : 32'(2 + waits));
      chk("valid_cycles", 32'(last_vc), cur.fault ? 32'd0 : 32'(waits + 1));
      @(negedge clk);
      chk("done_one_cycle", 32'({done, busy}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t tmp;
      bit   noisy;
      resetn    = 1'b0;
      start     = 1'b0;
      is_load   = 1'b0;
      load_op   = '0;
      store_op  = '0;
      addr      = 32'h0;
      wdata     = 32'h0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      cur       = '0;
      #2;
      chk("reset_ctrl", 32'({busy, done, mem_valid, misaligned, illegal_op}), 32'd0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_mem", mem_addr | mem_wdata | 32'(mem_wstrb), 32'h0);

      tmp = model(1'b1, `LOAD_OP_LB, `STORE_OP_SB, 32'h1003, 32'h0, 32'h80FF_FF00);
      chk("model_lb", tmp.rdata, 32'hFFFF_FF80);
      tmp = model(1'b0, `LOAD_OP_LB, `STORE_OP_SH, 32'h7002, 32'h0000_CAFE, 32'h0);
      chk("model_sh", {tmp.wdata[27:0], tmp.strb}, 32'hAFECAFE_C);

      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      do_req(1'b1, `LOAD_OP_LB, `STORE_OP_SB, 32'h1003, 32'h0, 32'h80FF_FF00, 0, 1'b0);
      chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
      chk("lb_addr", last_addr, 32'h0000_1000);
      chk("lb_wstrb", 32'(last_strb), 32'd0);

      do_req(1'b1, `LOAD_OP_LHU, `STORE_OP_SB, 32'h2002, 32'h0, 32'hBEEF_1234, 3, 1'b0);
      chk("lhu_rdata", last_rdata, 32'h0000_BEEF);
      chk("lhu_valid4", 32'(last_vc), 32'd4);

      do_req(1'b0, `LOAD_OP_LB, `STORE_OP_SB, 32'h3001, 32'h1234_56A5, 32'h0, 0, 1'b0);
      chk("sb_wstrb", 32'(last_strb), 32'b0010);
      chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
      chk("sb_rdata", last_rdata, 32'h0);

      do_req(1'b0, `LOAD_OP_LB, `STORE_OP_SW, 32'h4002, 32'h5555_AAAA, 32'h0, 0, 1'b0);
      chk("sw_mis", 32'({last_mis, last_ill}), 32'b10);
      chk("sw_lat", 32'(last_lat), 32'd1);

      do_req(1'b1, 3'b011, `STORE_OP_SB, 32'h5000, 32'h0, 32'h1234_5678, 0, 1'b0);
      chk("ill_load", 32'({last_mis, last_ill}), 32'b01);

      do_req(1'b1, `LOAD_OP_LH, `STORE_OP_SB, 32'h6002, 32'h0, 32'h8001_7FFF, 1, 1'b0);
      chk("lh_rdata", last_rdata, 32'hFFFF_8001);

      do_req(1'b0, `LOAD_OP_LB, `STORE_OP_SH, 32'h7002, 32'h0000_CAFE, 32'h0, 2, 1'b0);
      chk("sh_wstrb", 32'(last_strb), 32'b1100);
      chk("sh_wdata", last_wdata, 32'hCAFE_CAFE);

      do_req(1'b1, `LOAD_OP_LW, `STORE_OP_SB, 32'h8001, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
      do_req(1'b1, 3'b111, `STORE_OP_SB, 32'h8001, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
      chk("ill_over_mis", 32'({last_mis, last_ill}), 32'b01);
      do_req(1'b0, `LOAD_OP_LB, 2'b11, 32'h8100, 32'h1, 32'h0, 0, 1'b0);
      do_req(1'b1, `LOAD_OP_LBU, `STORE_OP_SB, 32'h9001, 32'h0, 32'h0000_9C00, 0, 1'b0);
      chk("lbu_rdata", last_rdata, 32'h0000_009C);

      // Start held high: one access per idle visit, next request taken right after done.
      do_req(1'b1, `LOAD_OP_LW, `STORE_OP_SB, 32'hA000, 32'h0, 32'h0BAD_F00D, 1, 1'b1);
      do_req(1'b1, `LOAD_OP_LW, `STORE_OP_SB, 32'hA000, 32'h0, 32'h0BAD_F00D, 0, 1'b1);
      start = 1'b0;
      chk("hold_second", last_rdata, 32'h0BAD_F00D);

      // Reset in the middle of an access.
      cur       = model(1'b1, `LOAD_OP_LW, `STORE_OP_SB, 32'h5000, 32'h0, 32'h1111_2222);
      is_load   = 1'b1;
      load_op   = `LOAD_OP_LW;
      addr      = 32'h5000;
      mem_rdata = 32'h1111_2222;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("rst_pre_valid", 32'(mem_valid), 32'd1);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      chk("rst_async_ctrl", 32'({busy, done, mem_valid, misaligned, illegal_op}), 32'd0);
      chk("rst_async_mem", mem_addr | mem_wdata | 32'(mem_wstrb) | rdata, 32'h0);
      mem_ready = 1'b1;
      noisy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy || mem_valid) noisy = 1'b1;
      end
      chk("rst_no_done", 32'(noisy), 32'd0);
      mem_ready = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      do_req(1'b1, `LOAD_OP_LW, `STORE_OP_SB, 32'h5004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      chk("post_rst_lw", last_rdata, 32'hDEAD_BEEF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
